// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready stream mux, fixed-select or round-robin, one registered output slot.
// Latency: 1 cycle from input transfer to out_valid; 1 word/cycle sustained while out_ready=1.
// Backpressure: in_ready drops on every channel while the output slot is full and out_ready=0.
// Optional packet lock (holds the grant until in_last) is built when STREAM_MUX_LOCK_EN is defined.
module stream_mux_rr #(
  parameter  int W  = 16,
  parameter  int N  = 4,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  input  logic [N-1:0]   in_last,
  output logic [N-1:0]   in_ready,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_ch,
  output logic           out_last,
  output logic           out_valid,
  input  logic           out_ready
);

  // Contents of the single output slot.
  typedef struct packed {
    logic [W-1:0]  dat;
    logic [SW-1:0] ch;
    logic          last;
  } out_t;

  out_t          out_q, out_d;
  logic          out_valid_q, out_valid_d;
  logic [SW-1:0] rr_ptr_q, rr_ptr_d;

`ifdef STREAM_MUX_LOCK_EN
  logic          lock_q, lock_d;
  logic [SW-1:0] lock_ch_q, lock_ch_d;
  logic [N-1:0]  lock_gnt;
`endif

  logic [N-1:0]  fix_gnt;
  logic [N-1:0]  rr_gnt;
  logic [N-1:0]  gnt;
  logic [SW-1:0] gnt_idx;
  logic [SW:0]   rr_cand;
  logic          rr_found;
  logic          load;
  logic          xfer;
  logic [W-1:0]  sel_dat;
  logic          sel_last;

  // Slot can take a new word when it is empty or being drained this cycle.
  assign load = ~out_valid_q | out_ready;

  // Fixed-select grant; a sel value of N or more matches no channel.
  always_comb begin
    fix_gnt = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == SW'(i)) begin
        fix_gnt[i] = 1'b1;
      end
    end
  end

  // Round-robin grant: first valid channel after rr_ptr, wrapping modulo N.
  always_comb begin
    rr_gnt   = '0;
    rr_found = 1'b0;
    rr_cand  = '0;
    for (int j = 1; j <= N; j++) begin
      rr_cand = {1'b0, rr_ptr_q} + (SW+1)'(j);
      if (rr_cand >= (SW+1)'(N)) begin
        rr_cand = rr_cand - (SW+1)'(N);
      end
      for (int i = 0; i < N; i++) begin
        if (!rr_found && in_valid[i] && (rr_cand == (SW+1)'(i))) begin
          rr_gnt[i] = 1'b1;
          rr_found  = 1'b1;
        end
      end
    end
  end

`ifdef STREAM_MUX_LOCK_EN
  // One-hot view of the channel that owns the open packet.
  always_comb begin
    lock_gnt = '0;
    for (int i = 0; i < N; i++) begin
      if (lock_ch_q == SW'(i)) begin
        lock_gnt[i] = 1'b1;
      end
    end
  end
`endif

  // Final grant: an open packet overrides both selection modes.
  always_comb begin
`ifdef STREAM_MUX_LOCK_EN
    if (lock_q) begin
      gnt = lock_gnt;
    end else begin
      gnt = mode ? rr_gnt : fix_gnt;
    end
`else
    gnt = mode ? rr_gnt : fix_gnt;
`endif
  end

  // Ready is forced low while reset is asserted, independent of the flops.
  assign in_ready = gnt & {N{load & rst_n}};
  assign xfer     = |(in_valid & in_ready);

  // Encode the grant and steer the granted channel's word and last flag.
  always_comb begin
    gnt_idx  = '0;
    sel_dat  = '0;
    sel_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        gnt_idx  = SW'(i);
        sel_dat  = in_data[i*W +: W];
        sel_last = in_last[i];
      end
    end
  end

  // Next state of the output slot, arbitration pointer and packet lock.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_d.dat  = sel_dat;
        out_d.ch   = gnt_idx;
        out_d.last = sel_last;
      end
    end
`ifdef STREAM_MUX_LOCK_EN
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
    if (xfer) begin
      lock_d    = ~sel_last;
      lock_ch_d = gnt_idx;
    end
    // Pointer advances once per packet, on the word that closes it.
    if (xfer && mode && sel_last) begin
      rr_ptr_d = gnt_idx;
    end
`else
    if (xfer && mode) begin
      rr_ptr_d = gnt_idx;
    end
`endif
  end

  // State registers; reset empties the slot and restarts arbitration at channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= SW'(N-1);
`ifdef STREAM_MUX_LOCK_EN
      lock_q      <= 1'b0;
      lock_ch_q   <= '0;
`endif
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef STREAM_MUX_LOCK_EN
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
`endif
    end
  end

  assign out_data  = out_q.dat;
  assign out_ch    = out_q.ch;
  assign out_last  = out_q.last;
  assign out_valid = out_valid_q;

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised successor to the team's fixed 4:1 16-bit combinational mux.
- Selects one of N valid/ready input streams of width W onto a single registered output stream.
- Two selection modes: externally driven select, or round-robin arbitration.
- Sits between multiple producer blocks and a single consumer, such as a display or bus interface.

Parameters:
- W, 16, data width per channel.
- N, 4, number of input channels (2..16).
- SW, derived as clog2(N) (2 for N=4), width of select and channel-ID fields; localparam, not overridable.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N*W  channel i occupies bits [i*W+W-1 : i*W].
- in_valid  input  N  per-channel data valid.
- in_last  input  N  per-channel end-of-packet flag; qualified by in_valid.
- in_ready  output  N  per-channel accept.
- mode  input  1  0 = fixed select by sel, 1 = round-robin.
- sel  input  SW  channel select, used only when mode=0.
- out_data  output  W  registered output data.
- out_ch  output  SW  index of the channel that supplied out_data.
- out_last  output  1  registered copy of the accepted in_last.
- out_valid  output  1  output data valid.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, out_data=0, out_ch=0, out_last=0, rr_ptr=N-1, lock=0. in_ready is all zero while rst_n=0.
- Output stage is a single register. load = ~out_valid | out_ready.
- Grant g is a one-hot combinational signal:
  - mode=0: g[sel]=1 if sel<N; if sel>=N, g=0 and no channel is ever accepted.
  - mode=1: g selects the first channel with in_valid=1, searching from rr_ptr+1 upward and wrapping modulo N. g=0 if no channel is valid.
- in_ready[i] = g[i] & load. This is combinational and must not depend on in_valid[i] in mode 0.
- Transfer on channel k when in_valid[k] & in_ready[k]. On the next edge:
  - out_data <= channel k data, out_ch <= k, out_last <= in_last[k], out_valid <= 1.
  - In mode 1, rr_ptr <= k.
- When load=1 and no transfer occurs, out_valid <= 0 on the next edge. out_data, out_ch and out_last hold their values.
- When out_valid=1 and out_ready=0, all outputs hold, and in_ready=0 on every channel.
- Latency is 1 cycle from input transfer to out_valid. Full throughput is 1 word/cycle while out_ready=1.
- rr_ptr changes only on a transfer in mode 1. In mode 0 rr_ptr holds.
- Changes to mode or sel take effect on the same cycle's grant. A word already in the output register is unaffected.
- At most one channel transfers per cycle. With N=2, wrap-around alternates 0,1,0,1 under continuous valid.
- Reset mid-operation drops any word held in the output register. No recovery or replay.

Optional Feature:
- Macro: STREAM_MUX_LOCK_EN.
- With the macro defined (packet lock):
  - After a transfer with in_last=0, set lock=1 and latch lock_ch=k.
  - While lock=1, g selects only lock_ch, regardless of mode, sel or other channels' valid.
  - A transfer with in_last=1 clears lock.
  - rr_ptr updates only on the transfer that clears lock, so arbitration is per packet.
  - Reset clears lock.
- Without the macro:
  - Arbitration is per word.
  - in_last is only passed through to out_last.
  - No lock or lock_ch registers are present.

Test Plan:
- Fixed select: mode=0, sel=2, out_ready=1, ch2 sends 0x1111,0x2222 → out_data 0x1111 then 0x2222 on consecutive cycles, out_ch=2, 1-cycle latency. Other channels' in_ready stay 0.
- Backpressure: out_ready=0 with out_valid=1 holding 0xABCD → in_ready=0 everywhere and out_data stays 0xABCD. Release out_ready → the next word lands on the following edge with no loss or duplication.
- Round-robin fairness: mode=1, all 4 channels valid continuously, out_ready=1 → out_ch sequence 0,1,2,3,0,1 after reset. Drop ch1 valid → sequence 0,2,3,0.
- Out-of-range select: N=3, mode=0, sel=3, all valid → in_ready=0 on all channels and out_valid=0 throughout.
- Reset mid-stream: assert rst_n=0 between clock edges while out_valid=1 → outputs clear immediately (asynchronously). After release, the first round-robin grant goes to channel 0.
- Packet lock (macro defined): mode=1, ch1 sends a 3-word packet (last on word 3) while ch2 is valid → out_ch=1,1,1 then 2. Without the macro → out_ch alternates 1,2,1,2.
